// File: rtl/adc_engine_pkg.sv
// Shared types and helpers for the ramp/SAR comparator ADC engine.
package adc_engine_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DECIDE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic MODE_RAMP = 1'b0;
  localparam logic MODE_SAR  = 1'b1;

  // (value * factor) >> shift, clamped to 16 bits for the display path.
  function automatic logic [15:0] scale_sat(input logic [31:0] value,
                                            input logic [31:0] factor,
                                            input int unsigned shift);
    logic [63:0] prod;
    prod = {32'b0, value} * {32'b0, factor};
    prod = prod >> shift;
    return (prod > 64'h0000_0000_0000_FFFF) ? 16'hFFFF : prod[15:0];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for the asynchronous comparator output.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ramp_sar_adc_engine.sv
// Ramp / successive-approximation conversion engine with averaging and scaling.
module ramp_sar_adc_engine
  import adc_engine_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned AVG_LOG2      = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned SCALE_FACTOR  = 3300,
  parameter int unsigned SHIFT_FACTOR  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             cmp_in,
  output logic [WIDTH-1:0] dac_code,
  output logic [WIDTH-1:0] raw_data,
  output logic [WIDTH-1:0] ave_data,
  output logic [15:0]      scaled_data,
  output logic             sample_valid,
  output logic             avg_valid,
  output logic             busy,
  output state_t           fsm_state
);

  localparam int unsigned ACC_W = WIDTH + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned SC_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned AVG_N = 1 << AVG_LOG2;
  localparam logic [WIDTH-1:0] CODE_MAX = '1;
  localparam logic [WIDTH-1:0] CODE_MSB = WIDTH'(1) << (WIDTH - 1);

  state_t           state, state_next;
  logic             mode_q;
  logic             cmp_s;
  logic [IDX_W-1:0] bit_idx;
  logic [SC_W-1:0]  settle_cnt;
  logic [WIDTH-1:0] result_q;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] sample_cnt;

  logic             decide_done;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] sar_keep;
  logic [ACC_W-1:0] acc_sum;
  logic [WIDTH-1:0] avg_new;

  sync_2ff u_cmp_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cmp_in),
    .q     (cmp_s)
  );

  assign busy      = (state != IDLE);
  assign fsm_state = state;

  // enable is a level request: while high, conversions run back to back and
  // each result is announced by a single-cycle sample_valid (avg_valid on the
  // last sample of an averaging window); there is no downstream backpressure.
  always_comb begin
    bit_mask    = WIDTH'(1) << bit_idx;
    sar_keep    = cmp_s ? dac_code : (dac_code & ~bit_mask);
    decide_done = (mode_q == MODE_RAMP) ? (!cmp_s || dac_code == CODE_MAX)
                                        : (bit_idx == '0);
    acc_sum     = acc + ACC_W'(result_q);
    avg_new     = WIDTH'(acc_sum >> AVG_LOG2);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = SETTLE;
      SETTLE: begin
        if (!enable) state_next = IDLE;
        else if (settle_cnt == SC_W'(SETTLE_CYCLES - 1)) state_next = DECIDE;
      end
      DECIDE: begin
        if (!enable) state_next = IDLE;
        else if (decide_done) state_next = DONE;
        else state_next = SETTLE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q       <= MODE_RAMP;
      dac_code     <= '0;
      bit_idx      <= '0;
      settle_cnt   <= '0;
      result_q     <= '0;
      acc          <= '0;
      sample_cnt   <= '0;
      raw_data     <= '0;
      ave_data     <= '0;
      scaled_data  <= '0;
      sample_valid <= 1'b0;
      avg_valid    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      avg_valid    <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            mode_q     <= mode;
            settle_cnt <= '0;
            if (mode == MODE_SAR) begin
              dac_code <= CODE_MSB;
              bit_idx  <= IDX_W'(WIDTH - 1);
            end else begin
              dac_code <= '0;
            end
          end
        end
        SETTLE: begin
          if (!enable) begin
            dac_code   <= '0;
            acc        <= '0;
            sample_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + SC_W'(1);
          end
        end
        DECIDE: begin
          if (!enable) begin
            dac_code   <= '0;
            acc        <= '0;
            sample_cnt <= '0;
          end else begin
            settle_cnt <= '0;
            if (mode_q == MODE_RAMP) begin
              if (cmp_s) begin
                if (dac_code == CODE_MAX) result_q <= CODE_MAX;
                else                      dac_code <= dac_code + WIDTH'(1);
              end else begin
                result_q <= (dac_code == '0) ? '0 : dac_code - WIDTH'(1);
              end
            end else begin
              // Keep or drop the trial bit, then try the next lower one.
              if (bit_idx != '0) begin
                dac_code <= sar_keep | (bit_mask >> 1);
                bit_idx  <= bit_idx - IDX_W'(1);
              end else begin
                result_q <= sar_keep;
              end
            end
          end
        end
        DONE: begin
          dac_code     <= '0;
          raw_data     <= result_q;
          sample_valid <= 1'b1;
          if (sample_cnt == CNT_W'(AVG_N - 1)) begin
            ave_data    <= avg_new;
            scaled_data <= scale_sat(32'(avg_new), 32'(SCALE_FACTOR), SHIFT_FACTOR);
            avg_valid   <= 1'b1;
            acc         <= '0;
            sample_cnt  <= '0;
          end else begin
            acc        <= acc_sum;
            sample_cnt <= sample_cnt + CNT_W'(1);
          end
        end
        default: dac_code <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ramp_sar_adc_engine.sv
// Directed bench for ramp_sar_adc_engine: three instances cover averaging depth and saturation.
module tb_ramp_sar_adc_engine;
  import adc_engine_pkg::*;

  localparam int LIMIT = 3000;

  logic       clk = 1'b0;
  logic       reset;
  logic       en   [3];
  logic       mode [3];
  logic [7:0] vin  [3];
  logic       cmp  [3];
  logic [7:0] dac  [3];
  logic [7:0] raw  [3];
  logic [7:0] ave  [3];
  logic [15:0] scl [3];
  logic       sv   [3];
  logic       av   [3];
  logic       busy [3];
  state_t     st   [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Ideal comparator: high while the DAC level is at or below the input.
  assign cmp[0] = (dac[0] <= vin[0]);
  assign cmp[1] = (dac[1] <= vin[1]);
  assign cmp[2] = (dac[2] <= vin[2]);

  ramp_sar_adc_engine #(.WIDTH(8), .AVG_LOG2(0), .SETTLE_CYCLES(4),
                        .SCALE_FACTOR(3300), .SHIFT_FACTOR(8)) u_avg0 (
    .clk(clk), .reset(reset), .enable(en[0]), .mode(mode[0]), .cmp_in(cmp[0]),
    .dac_code(dac[0]), .raw_data(raw[0]), .ave_data(ave[0]), .scaled_data(scl[0]),
    .sample_valid(sv[0]), .avg_valid(av[0]), .busy(busy[0]), .fsm_state(st[0]));

  ramp_sar_adc_engine #(.WIDTH(8), .AVG_LOG2(2), .SETTLE_CYCLES(4),
                        .SCALE_FACTOR(3300), .SHIFT_FACTOR(8)) u_avg2 (
    .clk(clk), .reset(reset), .enable(en[1]), .mode(mode[1]), .cmp_in(cmp[1]),
    .dac_code(dac[1]), .raw_data(raw[1]), .ave_data(ave[1]), .scaled_data(scl[1]),
    .sample_valid(sv[1]), .avg_valid(av[1]), .busy(busy[1]), .fsm_state(st[1]));

  ramp_sar_adc_engine #(.WIDTH(8), .AVG_LOG2(0), .SETTLE_CYCLES(4),
                        .SCALE_FACTOR(65535), .SHIFT_FACTOR(0)) u_sat (
    .clk(clk), .reset(reset), .enable(en[2]), .mode(mode[2]), .cmp_in(cmp[2]),
    .dac_code(dac[2]), .raw_data(raw[2]), .ave_data(ave[2]), .scaled_data(scl[2]),
    .sample_valid(sv[2]), .avg_valid(av[2]), .busy(busy[2]), .fsm_state(st[2]));

  // Waits for busy, then counts cycles until sample_valid; lat is measured from the first busy cycle.
  task automatic wait_conv(input int d, output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < LIMIT && !busy[d]; i++) @(negedge clk);
    if (!busy[d]) return;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      lat++;
      if (sv[d]) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      en[d] = 1'b0; mode[d] = 1'b0; vin[d] = 8'h00;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      tests++;
      if ({dac[d], raw[d], ave[d], scl[d], sv[d], av[d], busy[d]} !== 42'd0 || st[d] !== IDLE) begin
        fails++;
        $display("FAIL reset_state[%0d]: dac=%h raw=%h ave=%h scl=%h sv=%b av=%b busy=%b st=%0d, expected all 0 / IDLE",
                 d, dac[d], raw[d], ave[d], scl[d], sv[d], av[d], busy[d], st[d]);
      end
    end
  endtask

  task automatic test_sar_single();
    int lat; bit ok;
    vin[0] = 8'hA5; mode[0] = MODE_SAR; en[0] = 1'b1;
    wait_conv(0, lat, ok);
    en[0] = 1'b0;
    tests++;
    if (!ok || lat != 41) begin
      fails++; $display("FAIL sar_latency: got %0d (done=%b), expected 41", lat, ok);
    end
    tests++;
    if (raw[0] !== 8'hA5 || ave[0] !== 8'hA5 || av[0] !== 1'b1) begin
      fails++; $display("FAIL sar_result: raw=%h ave=%h av=%b, expected a5 a5 1", raw[0], ave[0], av[0]);
    end
    tests++;
    if (scl[0] !== 16'd2126) begin
      fails++; $display("FAIL sar_scaled: got %0d, expected 2126", scl[0]);
    end
    @(negedge clk);
    tests++;
    if (busy[0] !== 1'b0 || dac[0] !== 8'h00 || sv[0] !== 1'b0) begin
      fails++; $display("FAIL sar_idle_after: busy=%b dac=%h sv=%b, expected 0 00 0", busy[0], dac[0], sv[0]);
    end
  endtask

  task automatic test_ramp();
    int lat; bit ok;
    logic [7:0] vins [3];
    int         lats [3];
    vins[0] = 8'hA5; lats[0] = 836;
    vins[1] = 8'hFF; lats[1] = 1281;
    vins[2] = 8'h00; lats[2] = 11;
    mode[0] = MODE_RAMP;
    for (int k = 0; k < 3; k++) begin
      vin[0] = vins[k]; en[0] = 1'b1;
      wait_conv(0, lat, ok);
      en[0] = 1'b0;
      tests++;
      if (!ok || lat != lats[k]) begin
        fails++; $display("FAIL ramp_latency[%0d]: got %0d (done=%b), expected %0d", k, lat, ok, lats[k]);
      end
      tests++;
      if (raw[0] !== vins[k] || ave[0] !== vins[k]) begin
        fails++; $display("FAIL ramp_result[%0d]: raw=%h ave=%h, expected %h", k, raw[0], ave[0], vins[k]);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_sar_average();
    int lat; bit ok;
    logic [7:0] seq [4];
    seq[0] = 8'd10; seq[1] = 8'd20; seq[2] = 8'd30; seq[3] = 8'd41;
    mode[1] = MODE_SAR;
    for (int k = 0; k < 4; k++) begin
      vin[1] = seq[k]; en[1] = 1'b1;
      wait_conv(1, lat, ok);
      if (k == 3) en[1] = 1'b0;
      tests++;
      if (!ok || raw[1] !== seq[k] || av[1] !== (k == 3)) begin
        fails++; $display("FAIL avg_sample[%0d]: raw=%0d av=%b done=%b, expected raw=%0d av=%0d",
                          k, raw[1], av[1], ok, seq[k], (k == 3));
      end
    end
    tests++;
    if (ave[1] !== 8'd25 || scl[1] !== 16'd322) begin
      fails++; $display("FAIL avg_value: ave=%0d scl=%0d, expected 25 322", ave[1], scl[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_enable_drop();
    int lat; bit ok; bit pulse;
    logic [7:0] seq [4];
    mode[1] = MODE_RAMP; vin[1] = 8'd3; en[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_conv(1, lat, ok);
      tests++;
      if (!ok || lat != 26 || raw[1] !== 8'd3 || av[1] !== 1'b0) begin
        fails++; $display("FAIL drop_pre[%0d]: lat=%0d raw=%0d av=%b, expected 26 3 0", k, lat, raw[1], av[1]);
      end
    end
    for (int i = 0; i < LIMIT && !busy[1]; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    en[1] = 1'b0;
    @(negedge clk);
    tests++;
    if (busy[1] !== 1'b0 || dac[1] !== 8'h00 || st[1] !== IDLE) begin
      fails++; $display("FAIL drop_abort: busy=%b dac=%h st=%0d, expected 0 00 IDLE", busy[1], dac[1], st[1]);
    end
    pulse = sv[1] | av[1];
    repeat (3) begin
      @(negedge clk);
      pulse |= sv[1] | av[1];
    end
    tests++;
    if (pulse !== 1'b0 || raw[1] !== 8'd3 || ave[1] !== 8'd25 || scl[1] !== 16'd322) begin
      fails++; $display("FAIL drop_hold: pulse=%b raw=%0d ave=%0d scl=%0d, expected 0 3 25 322",
                        pulse, raw[1], ave[1], scl[1]);
    end
    seq[0] = 8'd4; seq[1] = 8'd8; seq[2] = 8'd12; seq[3] = 8'd16;
    for (int k = 0; k < 4; k++) begin
      vin[1] = seq[k]; en[1] = 1'b1;
      wait_conv(1, lat, ok);
      if (k == 3) en[1] = 1'b0;
      tests++;
      if (!ok || lat != (seq[k] + 2) * 5 + 1 || raw[1] !== seq[k] || av[1] !== (k == 3)) begin
        fails++; $display("FAIL drop_refill[%0d]: lat=%0d raw=%0d av=%b, expected %0d %0d %0d",
                          k, lat, raw[1], av[1], (seq[k] + 2) * 5 + 1, seq[k], (k == 3));
      end
    end
    tests++;
    if (ave[1] !== 8'd10 || scl[1] !== 16'd128) begin
      fails++; $display("FAIL drop_avg: ave=%0d scl=%0d, expected 10 128", ave[1], scl[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_mode_latch();
    int lat; bit ok;
    vin[0] = 8'h5A; mode[0] = MODE_SAR; en[0] = 1'b1;
    @(negedge clk);
    mode[0] = MODE_RAMP;
    wait_conv(0, lat, ok);
    en[0] = 1'b0;
    tests++;
    if (!ok || lat != 41 || raw[0] !== 8'h5A) begin
      fails++; $display("FAIL mode_latch: lat=%0d raw=%h, expected 41 5a", lat, raw[0]);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_saturate();
    int lat; bit ok;
    vin[2] = 8'hFF; mode[2] = MODE_SAR; en[2] = 1'b1;
    wait_conv(2, lat, ok);
    en[2] = 1'b0;
    tests++;
    if (!ok || raw[2] !== 8'hFF || ave[2] !== 8'hFF || scl[2] !== 16'hFFFF) begin
      fails++; $display("FAIL saturate: raw=%h ave=%h scl=%h, expected ff ff ffff", raw[2], ave[2], scl[2]);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    vin[2] = 8'h80; mode[2] = MODE_SAR; en[2] = 1'b1;
    for (int i = 0; i < LIMIT && !busy[2]; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    tests++;
    if (st[2] !== SETTLE) begin
      fails++; $display("FAIL reset_mid_pre: st=%0d, expected SETTLE", st[2]);
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({dac[2], raw[2], ave[2], scl[2], sv[2], av[2], busy[2]} !== 42'd0 || st[2] !== IDLE) begin
      fails++; $display("FAIL reset_mid: dac=%h raw=%h ave=%h scl=%h sv=%b av=%b busy=%b, expected all 0",
                        dac[2], raw[2], ave[2], scl[2], sv[2], av[2], busy[2]);
    end
    @(negedge clk);
    tests++;
    if (busy[2] !== 1'b0) begin
      fails++; $display("FAIL reset_wins: busy=%b with enable high in reset, expected 0", busy[2]);
    end
    reset = 1'b0;
    en[2] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sar_single();
    test_ramp();
    test_sar_average();
    test_enable_drop();
    test_mode_latch();
    test_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ramp_sar_adc_engine.md
Name: ramp_sar_adc_engine

Overview:
Parametrised software-free conversion engine for the external comparator ADC front-ends: a DAC (R2R ladder, or a PWM-filtered code) driven by dac_code, plus one analog comparator.
- Performs linear-ramp or successive-approximation conversions back to back while enabled.
- Averages 2^AVG_LOG2 samples and scales the average for the display/BCD path.
- Replaces the fixed 8-bit ramp-only processing with width, averaging depth, scaling and mode as parameters/inputs.

Parameters:
WIDTH, 8, DAC/result code width (4..12).
AVG_LOG2, 4, log2 of samples per average (0..8).
SETTLE_CYCLES, 16, clk cycles from a dac_code change to the comparator sample (>=3).
SCALE_FACTOR, 3300, multiplier applied to the averaged code.
SHIFT_FACTOR, 8, right shift applied after the multiply.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run conversions continuously while high
mode  in  1  0 = ramp, 1 = SAR; latched at conversion start
cmp_in  in  1  asynchronous comparator output, 1 = DAC level <= input
dac_code  out  WIDTH  code to the R2R/PWM DAC
raw_data  out  WIDTH  last completed conversion result
ave_data  out  WIDTH  last completed average (accumulator >> AVG_LOG2)
scaled_data  out  16  (ave_data*SCALE_FACTOR)>>SHIFT_FACTOR, saturated to 16'hFFFF
sample_valid  out  1  one-cycle pulse when raw_data updates
avg_valid  out  1  one-cycle pulse when ave_data/scaled_data update
busy  out  1  high whenever state != IDLE

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset state: all outputs 0, FSM in IDLE, accumulator and sample counter cleared, synchroniser flops cleared.
- cmp_in passes through a 2-flop synchroniser. Only the synchronised value is used.
- FSM states: IDLE, SETTLE, DECIDE, DONE.
- IDLE: when enable=1, latch mode into mode_q.
  - Ramp: dac_code <= 0.
  - SAR: dac_code <= MSB-only code, bit index <= WIDTH-1.
  - Next state SETTLE, settle counter <= 0.
- SETTLE: count SETTLE_CYCLES cycles, then go to DECIDE. dac_code is held constant.
- DECIDE, ramp mode:
  - cmp=1 and code < max: code+1, back to SETTLE.
  - cmp=1 at code = 2^WIDTH-1: result = max, go to DONE.
  - cmp=0: result = code-1, or 0 if code = 0; go to DONE.
- DECIDE, SAR mode:
  - If cmp=0, clear the trial bit.
  - If the bit index > 0, set the next lower bit, decrement the index, go to SETTLE.
  - Otherwise result = the kept code, go to DONE.
- DONE (1 cycle):
  - raw_data <= result; pulse sample_valid.
  - Add result to the accumulator (WIDTH+AVG_LOG2 bits) and increment the sample counter.
  - On the 2^AVG_LOG2-th sample: update ave_data and scaled_data, pulse avg_valid, clear the accumulator and counter.
  - Return to IDLE, dac_code <= 0. If enable is still high, the next conversion starts on the following cycle.
- Latency from leaving IDLE to the sample_valid cycle:
  - SAR: exactly WIDTH*(SETTLE_CYCLES+1)+1 cycles.
  - Ramp: (result+2)*(SETTLE_CYCLES+1)+1 cycles; (2^WIDTH)*(SETTLE_CYCLES+1)+1 cycles at full scale.
- Scaling:
  - Product width WIDTH+32 bits, computed in DONE from the new average.
  - ave_data and scaled_data update in the same cycle.
  - Any result above 16'hFFFF saturates to 16'hFFFF.
- enable deasserted mid-conversion: on the next edge, go to IDLE, dac_code <= 0, clear the accumulator and sample counter, no valid pulses. raw_data, ave_data and scaled_data hold their last values.
- mode changes mid-conversion are ignored until the next IDLE exit.
- reset wins over every other event in the same cycle.
- With AVG_LOG2 = 0, avg_valid coincides with every sample_valid and ave_data = raw_data.

Decomposition:
- Package adc_engine_pkg holds:
  - the state enum (IDLE, SETTLE, DECIDE, DONE);
  - MODE_RAMP = 1'b0 and MODE_SAR = 1'b1 constants;
  - a function computing the saturated 16-bit scale.
- One sub-module, sync_2ff, for the comparator synchroniser.
- Averaging and scaling stay inline in the engine.

Test Plan:
- Comparator model cmp_in = (dac_code <= vin_code); WIDTH=8, SETTLE_CYCLES=4.
- SAR, vin_code=8'hA5, AVG_LOG2=0 -> sample_valid 41 cycles after busy rises, raw_data=ave_data=8'hA5, scaled_data=(165*3300)>>8=2126.
- Ramp, vin_code=8'hA5 -> raw_data=8'hA5 after 836 cycles; vin_code=8'hFF -> raw_data=8'hFF; vin_code=0 -> raw_data=0 after 11 cycles.
- SAR, AVG_LOG2=2, vin_code sequence 10,20,30,41 -> three sample_valid with no avg_valid, then avg_valid with ave_data=25 and scaled_data=322.
- Ramp, enable dropped during the 3rd sample (AVG_LOG2=2) -> busy low, dac_code=0 next cycle, no pulses; re-enable -> 4 fresh samples are needed before avg_valid.
- SCALE_FACTOR=65535, SHIFT_FACTOR=0, vin_code=8'hFF -> scaled_data=16'hFFFF (saturated). Assert reset mid-SETTLE -> all outputs 0 on the next cycle.
